inv_addkey_mixcol_stage: RTL and testbench

Sequential decryption-round stage of the AES-256 decryption datapath. It sits directly after InvSubBytes and directly before the next round's InvShiftRows. It XORs the incoming 128-bit state with the round key (AddRoundKey), then applies InvMixColumns column-serially through `MixColumnHelper` instances. For the final decryption round, InvMixColumns is bypassed. The stage uses valid/ready handshakes on both sides and holds one transaction at a time.

---
 rtl/aes_dec_pkg.sv | 32 +++
 rtl/MixColumnHelper.sv | 45 ++++
 rtl/inv_addkey_mixcol_stage.sv | 110 +++++++++++
 tb/tb_inv_addkey_mixcol_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared types and helpers for the AES-256 decryption datapath.
//   state_t   : 128-bit AES state, column c at bits [127-32c -: 32],
//               row-0 byte is the MSB of each column.
//   col_t     : one 32-bit column.
//   NUM_COLS  : columns per state.
//   state_e   : FSM encoding shared by the round stages.
//   get_col() : extracts column c from a state.
package aes_dec_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic col_t get_col(input state_t s, input logic [1:0] c);
    col_t col;
    case (c)
      2'd0:    col = s[127:96];
      2'd1:    col = s[95:64];
      2'd2:    col = s[63:32];
      default: col = s[31:0];
    endcase
    return col;
  endfunction

endpackage

// File: rtl/MixColumnHelper.sv
// InvMixColumns on a single column, purely combinational.
//   col_i : input column  {a0,a1,a2,a3}, a0 = row 0 (MSB)
//   col_o : output column {b0,b1,b2,b3}
// Matrix rows: {0e,0b,0d,09} rotated right by one per output row.
module MixColumnHelper
  import aes_dec_pkg::*;
(
  input  col_t col_i,
  output col_t col_o
);

  // Multiply by x in GF(2^8) with the AES polynomial 0x11b.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign col_o[31:24] = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
  assign col_o[23:16] = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
  assign col_o[15:8]  = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
  assign col_o[7:0]   = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);

endmodule

// File: rtl/inv_addkey_mixcol_stage.sv
// AES-256 decryption round stage: AddRoundKey followed by column-serial
// InvMixColumns (bypassed on the final round). One transaction in flight.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake (state_in, round_key, skip_mix)
//   out_valid/out_ready : output handshake (state_out)
//   state_out           : result, equals the work register at all times
//   busy                : high while a transaction is held (BUSY or DONE)
//   dbg_state           : current FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both 1. in_ready is high only in IDLE, out_valid only in DONE; once
// out_valid is high, state_out holds steady until the output transfer.
module inv_addkey_mixcol_stage
  import aes_dec_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         skip_mix,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_e     state_q, state_d;
  state_t     work_q, work_d;
  logic [1:0] col_cnt_q, col_cnt_d;

  col_t mix_in  [COLS_PER_CYCLE];
  col_t mix_out [COLS_PER_CYCLE];

  // Group g of the current BUSY cycle handles column col_cnt_q + g.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
    assign mix_in[g] = get_col(work_q, col_cnt_q + 2'(g));
    MixColumnHelper u_mix (
      .col_i (mix_in[g]),
      .col_o (mix_out[g])
    );
  end

  // The last group of a pass starts at column NUM_COLS - COLS_PER_CYCLE.
  logic last_group;
  assign last_group = (col_cnt_q == 2'(NUM_COLS - COLS_PER_CYCLE));

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    col_cnt_d = col_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d    = state_in ^ round_key;
          col_cnt_d = 2'd0;
          state_d   = skip_mix ? DONE : BUSY;
        end
      end
      BUSY: begin
        for (int c = 0; c < NUM_COLS; c++) begin
          for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            if (col_cnt_q + 2'(g) == 2'(c)) begin
              work_d[127-32*c -: 32] = mix_out[g];
            end
          end
        end
        col_cnt_d = col_cnt_q + 2'(COLS_PER_CYCLE);
        if (last_group) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      work_q    <= '0;
      col_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      col_cnt_q <= col_cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY) || (state_q == DONE);
  assign state_out = work_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_inv_addkey_mixcol_stage.sv
// Directed bench for inv_addkey_mixcol_stage. Three instances (1, 2 and 4
// columns per cycle) share clock and reset; each has its own handshake.
module tb_inv_addkey_mixcol_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         in_valid_a  [3];
  logic         in_ready_a  [3];
  logic [127:0] state_in_a  [3];
  logic [127:0] round_key_a [3];
  logic         skip_mix_a  [3];
  logic         out_valid_a [3];
  logic         out_ready_a [3];
  logic [127:0] state_out_a [3];
  logic         busy_a      [3];
  logic [1:0]   dbg_state_a [3];

  int errors = 0;
  int checks = 0;

  // Hand-computed vectors (known AES MixColumns pairs, inverted).
  localparam logic [127:0] VEC_A_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] VEC_A_EXP = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] VEC_B_IN  = 128'h4d7ebdf8_c6c6c6c6_8e4da1bc_01010101;
  localparam logic [127:0] VEC_B_EXP = 128'h2d26314c_c6c6c6c6_db135345_01010101;
  localparam logic [127:0] KEY_A5    = {16{8'ha5}};
  localparam logic [127:0] SKIP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] SKIP_EXP  = 128'hffeeddcc_bbaa9988_77665544_33221100;

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int P = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    inv_addkey_mixcol_stage #(.COLS_PER_CYCLE(P)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .state_in  (state_in_a[g]),
      .round_key (round_key_a[g]),
      .skip_mix  (skip_mix_a[g]),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .state_out (state_out_a[g]),
      .busy      (busy_a[g]),
      .dbg_state (dbg_state_a[g])
    );
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a transaction on instance idx and wait for out_valid; out_ready
  // stays low so the result is left sitting in DONE.
  task automatic run_txn(input int idx, input logic [127:0] st, input logic [127:0] key,
                         input logic skip, input logic [127:0] exp, input int exp_lat,
                         input string tag);
    int k;
    check({tag, ".ready"}, in_ready_a[idx], 1'b1);
    state_in_a[idx]  = st;
    round_key_a[idx] = key;
    skip_mix_a[idx]  = skip;
    in_valid_a[idx]  = 1'b1;
    tick();                       // accept edge E0
    in_valid_a[idx]  = 1'b0;
    k = 0;
    while (!out_valid_a[idx] && k < 16) begin
      check({tag, ".busy"}, {in_ready_a[idx], busy_a[idx]}, 2'b01);
      tick();
      k++;
    end
    check({tag, ".lat"}, 128'(k), 128'(exp_lat));
    check({tag, ".ovalid"}, out_valid_a[idx], 1'b1);
    check({tag, ".data"}, state_out_a[idx], exp);
  endtask

  task automatic finish_txn(input int idx, input string tag);
    out_ready_a[idx] = 1'b1;
    tick();                       // output handshake edge
    out_ready_a[idx] = 1'b0;
    check({tag, ".rdy_back"}, {in_ready_a[idx], out_valid_a[idx], busy_a[idx]}, 3'b100);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] held;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i]  = 1'b0;
      out_ready_a[i] = 1'b0;
      state_in_a[i]  = '0;
      round_key_a[i] = '0;
      skip_mix_a[i]  = 1'b0;
    end

    // Reset values
    tick();
    tick();
    check("reset.ctrl", {in_ready_a[0], out_valid_a[0], busy_a[0]}, 3'b100);
    check("reset.data", state_out_a[0], '0);
    rst = 1'b0;
    tick();

    // Basic InvMixColumns
    run_txn(0, VEC_A_IN, '0, 1'b0, VEC_A_EXP, 4, "basic");
    finish_txn(0, "basic");

    // AddRoundKey then InvMixColumns
    run_txn(0, VEC_A_IN ^ KEY_A5, KEY_A5, 1'b0, VEC_A_EXP, 4, "addkey");
    finish_txn(0, "addkey");

    // Skip path
    run_txn(0, SKIP_IN, {128{1'b1}}, 1'b1, SKIP_EXP, 0, "skip");
    finish_txn(0, "skip");

    // Backpressure: result held, new vector offered but refused
    run_txn(0, SKIP_IN, {128{1'b1}}, 1'b1, SKIP_EXP, 0, "bp_first");
    held = state_out_a[0];
    state_in_a[0]  = VEC_B_IN;
    round_key_a[0] = '0;
    skip_mix_a[0]  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid_a[0] = (i % 2 == 0);
      tick();
      check("bp.hold", state_out_a[0], held);
      check("bp.ctrl", {in_ready_a[0], out_valid_a[0]}, 2'b01);
    end
    in_valid_a[0] = 1'b0;
    finish_txn(0, "bp");
    run_txn(0, VEC_B_IN, '0, 1'b0, VEC_B_EXP, 4, "bp_next");
    finish_txn(0, "bp_next");

    // Reset after two columns processed
    state_in_a[0]  = VEC_A_IN;
    round_key_a[0] = '0;
    skip_mix_a[0]  = 1'b0;
    in_valid_a[0]  = 1'b1;
    tick();                       // E0
    in_valid_a[0]  = 1'b0;
    tick();                       // E1: column 0
    tick();                       // E2: column 1
    check("mid.busy", dbg_state_a[0], 2'd1);
    #1 rst = 1'b1;
    #1;
    check("mid.rst_ctrl", {in_ready_a[0], out_valid_a[0], busy_a[0]}, 3'b100);
    check("mid.rst_data", state_out_a[0], '0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("mid.no_ovalid", out_valid_a[0], 1'b0);
      tick();
    end
    run_txn(0, VEC_A_IN, '0, 1'b0, VEC_A_EXP, 4, "post_rst");
    finish_txn(0, "post_rst");

    // Parameter sweep
    run_txn(1, VEC_A_IN, '0, 1'b0, VEC_A_EXP, 2, "cpc2");
    finish_txn(1, "cpc2");
    run_txn(2, VEC_A_IN, '0, 1'b0, VEC_A_EXP, 1, "cpc4");
    finish_txn(2, "cpc4");
    run_txn(1, VEC_B_IN, '0, 1'b0, VEC_B_EXP, 2, "cpc2b");
    finish_txn(1, "cpc2b");
    run_txn(2, VEC_B_IN ^ KEY_A5, KEY_A5, 1'b0, VEC_B_EXP, 1, "cpc4b");
    finish_txn(2, "cpc4b");

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
